// File: rtl/parity_store_pkg.sv
// Shared definitions for the parity-protected word store: word layout, FSM state codes
// and the parity rule used by both the scan and host read paths.
package parity_store_pkg;

    localparam int WORD_W = 9;
    localparam int DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_SCAN_ADDR = 3'd1;
    localparam state_t S_SCAN_CHK  = 3'd2;
    localparam state_t S_HOST_ADDR = 3'd3;
    localparam state_t S_HOST_CHK  = 3'd4;
    localparam state_t S_DONE      = 3'd5;

    // A word is good when the XOR of its data field equals the stored parity bit (LSB).
    function automatic logic parity_ok(input logic [WORD_W-1:0] word);
        return (^word[WORD_W-1:1]) == word[0];
    endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational split of a store word into its data field and a parity-failure flag.
module parity_word_check
    import parity_store_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    assign data_o = word_i[WORD_W-1:1];
    assign err_o  = !parity_ok(word_i);

endmodule

// File: rtl/parity_scan_controller.sv
// Background parity scanner for the shared word store, arbitrating its single read port
// with host reads; the host wins at word boundaries and a suspended scan resumes afterwards.
module parity_scan_controller
    import parity_store_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_perr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                susp_q, susp_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fev_q, fev_d;
    logic [ADDR_W-1:0]   fea_q, fea_d;

    logic [DATA_W-1:0]   chk_data;
    logic                chk_err;

    parity_word_check u_check (
        .word_i (word_q),
        .data_o (chk_data),
        .err_o  (chk_err)
    );

    // ptr_q always names the next scan word to read, so a suspended scan resumes from it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        susp_d     = susp_q;
        pend_d     = pend_q;
        mem_addr_d = mem_addr_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        fev_d      = fev_q;
        fea_d      = fea_q;
        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d    = S_HOST_ADDR;
                    mem_addr_d = host_addr;
                    if (start) pend_d = 1'b1;
                end else if (start || pend_q) begin
                    state_d    = S_SCAN_ADDR;
                    ptr_d      = '0;
                    mem_addr_d = '0;
                    cnt_d      = '0;
                    fev_d      = 1'b0;
                    fea_d      = '0;
                    pend_d     = 1'b0;
                end
            end
            S_SCAN_ADDR: begin
                word_d  = mem_rdata;
                state_d = abort ? S_IDLE : S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (chk_err) begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fea_d = ptr_q;
                        end
                    end
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_DONE;
                    end else if (host_req) begin
                        state_d    = S_HOST_ADDR;
                        mem_addr_d = host_addr;
                        ptr_d      = ptr_q + ADDR_W'(1);
                        susp_d     = 1'b1;
                    end else begin
                        state_d    = S_SCAN_ADDR;
                        ptr_d      = ptr_q + ADDR_W'(1);
                        mem_addr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_HOST_ADDR: begin
                word_d  = mem_rdata;
                state_d = S_HOST_CHK;
                if (abort) susp_d = 1'b0;
            end
            S_HOST_CHK: begin
                susp_d = 1'b0;
                if (susp_q && !abort) begin
                    state_d    = S_SCAN_ADDR;
                    mem_addr_d = ptr_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            susp_q     <= 1'b0;
            pend_q     <= 1'b0;
            mem_addr_q <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            fev_q      <= 1'b0;
            fea_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            susp_q     <= susp_d;
            pend_q     <= pend_d;
            mem_addr_q <= mem_addr_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            fev_q      <= fev_d;
            fea_q      <= fea_d;
        end
    end

    assign host_gnt        = (state_q == S_HOST_ADDR);
    assign host_rvalid     = (state_q == S_HOST_CHK);
    assign host_rdata      = host_rvalid ? chk_data : '0;
    assign host_perr       = host_rvalid && chk_err;
    assign mem_addr        = mem_addr_q;
    assign busy            = (state_q == S_SCAN_ADDR) || (state_q == S_SCAN_CHK) ||
                             (((state_q == S_HOST_ADDR) || (state_q == S_HOST_CHK)) && susp_q);
    assign done            = (state_q == S_DONE);
    assign err_count       = cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_addr  = fea_q;

endmodule
